can_tx_scheduler: RTL

- Upstream stage for the packet-level CAN controller's user TX interface.
- Buffers 32-bit payload words from the user in a small FIFO and presents them one at a time on tx_start/tx_data.
- Holds each request until the controller reports tx_done. Retransmits on missing ACK up to a retry limit, and aborts on a watchdog timeout.
- Emits one status pulse per frame.

---
 rtl/can_tx_scheduler_if.sv | 39 +++
 rtl/can_tx_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/can_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : can_tx_scheduler_if
// Purpose  : Bundles the user word handshake, the packet-controller request
//            and completion signals, and the per-word status outputs of
//            can_tx_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface can_tx_scheduler_if;
  // user word handshake
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  // packet controller request and completion
  logic        tx_start;
  logic [31:0] tx_data;
  logic        tx_done;
  logic        tx_acked;
  // per-word status
  logic        st_valid;
  logic        st_ok;
  logic        st_timeout;
  logic [3:0]  st_tries;

  // environment side: the user plus the packet controller
  modport master (
    output in_valid, in_data, tx_done, tx_acked,
    input  in_ready, tx_start, tx_data,
    input  st_valid, st_ok, st_timeout, st_tries
  );

  // scheduler side
  modport slave (
    input  in_valid, in_data, tx_done, tx_acked,
    output in_ready, tx_start, tx_data,
    output st_valid, st_ok, st_timeout, st_tries
  );
endinterface
`default_nettype wire

// File: rtl/can_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : can_tx_scheduler
// Purpose  : Buffers 32-bit user words in a small FIFO and hands them one at
//            a time to the packet CAN controller. Each word is retried on a
//            missing ACK up to MAX_TRIES, aborted by a per-attempt watchdog,
//            and reported with a single status pulse.
// Options  : CAN_TX_STAT_CNT_EN adds saturating cnt_ok / cnt_fail outputs.
// Revision : 1.0 - initial release
// ============================================================================
module can_tx_scheduler #(
  parameter int          FIFO_AW     = 2,
  parameter int          MAX_TRIES   = 4,
  parameter logic [31:0] TIMEOUT_CYC = 32'd2000000
) (
  input  wire logic         clk,
  input  wire logic         rstn,
  can_tx_scheduler_if.slave bus,
  output logic              busy
`ifdef CAN_TX_STAT_CNT_EN
  ,
  output logic [15:0]       cnt_ok,
  output logic [15:0]       cnt_fail
`endif
);

  localparam int             DEPTH     = 2**FIFO_AW;
  localparam logic [3:0]     TRIES_MAX = 4'(MAX_TRIES);
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    REQ    = 3'd2,
    GAP    = 3'd3,
    REPORT = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               push;
  logic               pop;

  // FSM state and its registered outputs
  state_t      state,    state_nxt;
  logic        req_q,    req_nxt;
  logic [31:0] word_q,   word_nxt;
  logic [3:0]  tries_q,  tries_nxt;
  logic [31:0] wdog_q,   wdog_nxt;
  logic        stv_q,    stv_nxt;
  logic        sok_q,    sok_nxt;
  logic        stmo_q,   stmo_nxt;
  logic [3:0]  stry_q,   stry_nxt;

  assign full = (count == FULL_CNT);
  // A push while full would be dropped; the handshake never offers one.
  assign push = bus.in_valid && !full;

  // FIFO write port; contents need no reset since count marks validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the depth
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register plus all registered request/status outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      word_q  <= '0;
      tries_q <= '0;
      wdog_q  <= '0;
      stv_q   <= 1'b0;
      sok_q   <= 1'b0;
      stmo_q  <= 1'b0;
      stry_q  <= '0;
    end else begin
      state   <= state_nxt;
      req_q   <= req_nxt;
      word_q  <= word_nxt;
      tries_q <= tries_nxt;
      wdog_q  <= wdog_nxt;
      stv_q   <= stv_nxt;
      sok_q   <= sok_nxt;
      stmo_q  <= stmo_nxt;
      stry_q  <= stry_nxt;
    end
  end

  // FSM next state: fetch, request, retry after a gap, report once per word
  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    word_nxt  = word_q;
    tries_nxt = tries_q;
    wdog_nxt  = wdog_q;
    stv_nxt   = 1'b0;
    sok_nxt   = sok_q;
    stmo_nxt  = stmo_q;
    stry_nxt  = stry_q;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          word_nxt  = mem[rd_ptr];
          tries_nxt = 4'd1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        req_nxt   = 1'b1;
        wdog_nxt  = '0;
        state_nxt = REQ;
      end
      REQ: begin
        if (wdog_q != 32'hFFFF_FFFF) wdog_nxt = wdog_q + 32'd1;
        // A completion in the same cycle as watchdog expiry takes priority.
        if (bus.tx_done) begin
          req_nxt = 1'b0;
          if (bus.tx_acked) begin
            stv_nxt   = 1'b1;
            sok_nxt   = 1'b1;
            stmo_nxt  = 1'b0;
            stry_nxt  = tries_q;
            state_nxt = REPORT;
          end else if (tries_q < TRIES_MAX) begin
            tries_nxt = tries_q + 4'd1;
            state_nxt = GAP;
          end else begin
            stv_nxt   = 1'b1;
            sok_nxt   = 1'b0;
            stmo_nxt  = 1'b0;
            stry_nxt  = tries_q;
            state_nxt = REPORT;
          end
        end else if (wdog_q == TIMEOUT_CYC - 32'd1) begin
          req_nxt   = 1'b0;
          stv_nxt   = 1'b1;
          sok_nxt   = 1'b0;
          stmo_nxt  = 1'b1;
          stry_nxt  = tries_q;
          state_nxt = REPORT;
        end
      end
      GAP:     state_nxt = LOAD;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready   = !full;
  assign bus.tx_start   = req_q;
  assign bus.tx_data    = word_q;
  assign bus.st_valid   = stv_q;
  assign bus.st_ok      = sok_q;
  assign bus.st_timeout = stmo_q;
  assign bus.st_tries   = stry_q;
  assign busy           = (count != '0) || (state != IDLE);

`ifdef CAN_TX_STAT_CNT_EN
  // Saturating delivered / failed word counters driven by the status pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_ok   <= '0;
      cnt_fail <= '0;
    end else if (stv_q) begin
      if (sok_q) begin
        if (cnt_ok != 16'hFFFF) cnt_ok <= cnt_ok + 16'd1;
      end else begin
        if (cnt_fail != 16'hFFFF) cnt_fail <= cnt_fail + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
